// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the core and the iterative RV32M unit.
// The core drives the master side; the multiply/divide unit is the slave.
interface riscv_muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on
// operand magnitudes, then one sign-fixup cycle. Fixed 34-edge latency.
module riscv_muldiv (
  input  logic           clk,
  input  logic           nrst,
  riscv_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [4:0]  count;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        sign_a, sign_b, div_zero;
  logic [63:0] prod;
  logic [31:0] mcand;

  logic        signed_a, signed_b, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_tmp;
  logic        div_ge;
  logic [31:0] div_hi;
  logic [63:0] mul_step, div_step, mul_fix;
  logic [31:0] quot, rem, fix_val;

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (count == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        bus.busy  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU signed rs1 only.
  always_comb begin
    signed_a = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    signed_b = signed_a && (bus.funct3 != 3'b010);
    sa       = signed_a & bus.op_a[31];
    sb       = signed_b & bus.op_b[31];
    a_mag    = sa ? -bus.op_a : bus.op_a;
    b_mag    = sb ? -bus.op_b : bus.op_b;
  end

  always_comb begin
    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    mul_step = {mul_sum, prod[31:1]};
    div_tmp  = prod[63:31];
    div_ge   = div_tmp >= {1'b0, mcand};
    div_hi   = div_ge ? (div_tmp[31:0] - mcand) : div_tmp[31:0];
    div_step = {div_hi, prod[30:0], div_ge};
  end

  // A zero divisor leaves the dividend magnitude in the remainder half, so
  // applying the dividend sign yields the required REM result unchanged; only
  // the quotient needs overriding. Signed overflow falls out naturally.
  always_comb begin
    mul_fix = (sign_a ^ sign_b) ? -prod : prod;
    quot    = (sign_a ^ sign_b) ? -prod[31:0] : prod[31:0];
    if (div_zero) quot = '1;
    rem     = sign_a ? -prod[63:32] : prod[63:32];
    case (op_q)
      3'b000:                 fix_val = mul_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_val = mul_fix[63:32];
      3'b100, 3'b101:         fix_val = quot;
      default:                fix_val = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      div_zero   <= 1'b0;
      prod       <= '0;
      mcand      <= '0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else if (accept) begin
      count    <= '0;
      op_q     <= bus.funct3;
      rd_q     <= bus.rd_in;
      sign_a   <= sa;
      sign_b   <= sb;
      div_zero <= (bus.op_b == 32'd0);
      if (bus.funct3[2]) begin
        prod  <= {32'd0, a_mag};
        mcand <= b_mag;
      end else begin
        prod  <= {32'd0, b_mag};
        mcand <= a_mag;
      end
    end else if (state == CALC) begin
      count <= count + 5'd1;
      prod  <= op_q[2] ? div_step : mul_step;
    end else if (state == FIX) begin
      bus.result <= fix_val;
      bus.rd_out <= rd_q;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv: latency, results, handshake and
// mid-operation reset, with hand-computed expectations.
module tb_riscv_muldiv;

  logic clk;
  logic nrst;
  riscv_muldiv_if bus ();

  riscv_muldiv dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edges    = 0;
  int unsigned busy_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    edges      = 0;
    busy_cnt   = 0;
    step();
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom_range(7, 0));
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.rd_in  = 5'($urandom_range(31, 0));
    chk({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input logic [31:0] exp, input logic [4:0] rd, input string tag);
    while (!bus.done && edges < 60) step();
    chk({tag, "_latency"}, 64'(edges), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, "_result"}, 64'(bus.result), 64'(exp));
    chk({tag, "_rd"}, 64'(bus.rd_out), 64'(rd));
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input string tag);
    issue(f, a, b, rd, tag);
    wait_done(exp, rd, tag);
    step();
    chk({tag, "_done_width"}, 64'(bus.done), 64'd0);
  endtask

  int unsigned n_done;

  initial begin
    nrst       = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_rd",     64'(bus.rd_out), 64'd0);
    nrst = 1'b1;
    step();

    run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, "mul");
    run(3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, "mulh");
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, "mulhu");
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, "mulhsu");
    run(3'b000, 32'h80000000, 32'd2,        5'd6,  32'h00000000, "mul_wrap");
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, "div_neg");
    run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, "rem_neg");
    run(3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       "divu");
    run(3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        "remu");
    run(3'b110, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        "rem_negdiv");
    run(3'b100, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, "div_zero");
    run(3'b110, 32'd5,        32'd0,        5'd16, 32'd5,        "rem_zero");
    run(3'b101, 32'hFFFFFFFF, 32'd0,        5'd17, 32'hFFFFFFFF, "divu_zero");
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, "div_ovf");
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        "rem_ovf");
    run(3'b000, 32'd9,        32'd9,        5'd0,  32'd81,       "mul_x0");

    // Start while busy must be ignored; start in the DONE cycle is accepted.
    issue(3'b000, 32'd3, 32'd5, 5'd3, "hs1");
    repeat (9) step();
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.op_a   = 32'h00001234;
    bus.op_b   = 32'h00000055;
    bus.rd_in  = 5'd9;
    step();
    bus.start  = 1'b0;
    wait_done(32'd15, 5'd3, "hs1");
    issue(3'b000, 32'd6, 32'd7, 5'd11, "hs2");
    chk("hs_hold_result", 64'(bus.result), 64'd15);
    chk("hs_hold_rd",     64'(bus.rd_out), 64'd3);
    wait_done(32'd42, 5'd11, "hs2");
    step();
    chk("hs2_done_width", 64'(bus.done), 64'd0);

    // Reset in the middle of a divide.
    issue(3'b100, 32'hFFFFFF9C, 32'd7, 5'd13, "rst_mid");
    repeat (14) step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("rstmid_busy",   64'(bus.busy),   64'd0);
    chk("rstmid_result", 64'(bus.result), 64'd0);
    chk("rstmid_rd",     64'(bus.rd_out), 64'd0);
    chk("rstmid_done",   64'(bus.done),   64'd0);
    n_done = 0;
    repeat (40) begin
      step();
      if (bus.done) n_done++;
    end
    chk("rstmid_no_done", 64'(n_done), 64'd0);
    run(3'b100, 32'hFFFFFF9C, 32'd7, 5'd13, 32'hFFFFFFF2, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
